// File: rtl/prog_load_seq.sv
// Program loader/sequencer: streams words into instruction memory, runs the CPU for N cycles, captures results.
// Latency: memory write is combinational with the accepted word; result registers update on the CAPTURE exit edge.
// Backpressure: in_ready is high only in LOAD; in_valid low there stalls the load indefinitely.
module prog_load_seq #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       run_cycles,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  input  logic [31:0]       reg0_in,
  input  logic [31:0]       flag_in,
  output logic [31:0]       result_reg0,
  output logic [31:0]       result_flag,
  output logic [ADDR_W:0]   words_loaded,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_run_cycles;
  logic [15:0]       r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;
  logic              r_error;
  logic [31:0]       r_result_reg0;
  logic [31:0]       r_result_flag;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_at_end;
  logic              w_cpu_reset;
  logic              w_done;

  // Reset cycle blocks the handshake so no write can slip through while reset is asserted.
  assign w_in_ready = (r_state == S_LOAD) && reset;
  assign w_accept   = in_valid && w_in_ready;
  assign w_at_end   = (r_addr == LP_LAST_ADDR);

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next      = r_state;
    w_cpu_reset = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_accept) begin
          if (in_last) begin
            // A zero-length run never releases the CPU.
            w_next = (r_run_cycles == 16'd0) ? S_CAPTURE : S_RUN;
          end else if (w_at_end) begin
            w_next = S_CAPTURE;
          end
        end
      end
      S_RUN: begin
        w_cpu_reset = 1'b0;
        if (r_cnt <= 16'd1) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Load address/count, run counter, sticky overflow and result capture.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_run_cycles  <= '0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_words       <= '0;
      r_error       <= 1'b0;
      r_result_reg0 <= '0;
      r_result_flag <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_run_cycles <= run_cycles;
        r_addr       <= '0;
        r_words      <= '0;
        r_error      <= 1'b0;
      end
      if (w_accept) begin
        r_addr  <= r_addr + 1'b1;
        r_words <= r_words + 1'b1;
        if (!in_last && w_at_end) r_error <= 1'b1;
      end
      if ((r_state == S_LOAD) && (w_next == S_RUN)) begin
        r_cnt <= r_run_cycles;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - 16'd1;
      end
      // CPU outputs during CAPTURE reflect exactly run_cycles executed edges.
      if (r_state == S_CAPTURE) begin
        r_result_reg0 <= reg0_in;
        r_result_flag <= flag_in;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign imem_we      = w_accept;
  assign imem_addr    = r_addr;
  assign imem_wdata   = in_data;
  assign cpu_reset    = w_cpu_reset;
  assign result_reg0  = r_result_reg0;
  assign result_flag  = r_result_flag;
  assign words_loaded = r_words;
  assign busy         = (r_state != S_IDLE);
  assign done         = w_done;
  assign error        = r_error;

endmodule

// File: tb/tb_prog_load_seq.sv
// Directed bench for prog_load_seq with DEPTH=4 so overflow is reachable.
// Inputs are driven 1 time unit after the rising edge; outputs checked 1 unit later.
// A negedge monitor tallies writes, cpu_reset-low cycles and done pulses.
module tb_prog_load_seq;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic              Clock = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0]       run_cycles;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic [31:0]       reg0_in;
  logic [31:0]       flag_in;
  logic [31:0]       result_reg0;
  logic [31:0]       result_flag;
  logic [ADDR_W:0]   words_loaded;
  logic              busy;
  logic              done;
  logic              error;

  prog_load_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .reset(reset), .start(start), .run_cycles(run_cycles),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .reg0_in(reg0_in), .flag_in(flag_in),
    .result_reg0(result_reg0), .result_flag(result_flag),
    .words_loaded(words_loaded), .busy(busy), .done(done), .error(error)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  int wr_cnt = 0;
  int low_cnt = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];

  always @(negedge Clock) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_cnt = wr_cnt + 1;
    end
    if (cpu_reset === 1'b0) low_cnt = low_cnt + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      cyc();
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Issue a start from IDLE and step into LOAD.
  task automatic do_start(input logic [15:0] rc);
    start = 1'b1;
    run_cycles = rc;
    cyc();
    start = 1'b0;
  endtask

  // Present one word in LOAD, check the zero-latency write, then step.
  task automatic put_word(input string tag, input logic [31:0] d, input logic last,
                          input logic [ADDR_W-1:0] exp_addr);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd1);
    chk({tag, "_addr"}, {29'd0, imem_addr}, {29'd0, exp_addr});
    chk({tag, "_wdata"}, imem_wdata, d);
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int w0, l0, d0, qb, n, acc;
    logic pat [5];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;

    reset = 1'b0; start = 1'b0; run_cycles = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; reg0_in = '0; flag_in = '0;
    cyc(); cyc();
    // Reset state, with in_valid asserted to prove no write in reset.
    in_valid = 1'b1;
    #1;
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_res0", result_reg0, 32'd0);
    chk("rst_words", {28'd0, words_loaded}, 32'd0);
    reset = 1'b1;
    cyc();
    chk("idle_we", {31'd0, imem_we}, 32'd0);
    in_valid = 1'b0;

    // Normal run: 3 words, 5 run cycles, capture value changed in CAPTURE.
    w0 = wr_cnt; l0 = low_cnt; d0 = done_cnt; qb = wr_addr_q.size();
    do_start(16'd5);
    chk("n_in_ready", {31'd0, in_ready}, 32'd1);
    chk("n_load_cpurst", {31'd0, cpu_reset}, 32'd1);
    put_word("n_w0", 32'hC0DE_0000, 1'b0, 3'd0);
    put_word("n_w1", 32'hC0DE_0001, 1'b0, 3'd1);
    put_word("n_w2", 32'hC0DE_0002, 1'b1, 3'd2);
    reg0_in = 32'h1111_1111; flag_in = 32'h0000_0001;
    #1;
    chk("n_run_cpurst", {31'd0, cpu_reset}, 32'd0);
    wait_done(50, n);
    chk("n_run_len", n, 32'd5);
    reg0_in = 32'hA5A5_0003; flag_in = 32'h0000_0004;
    cyc();
    chk("n_res0", result_reg0, 32'hA5A5_0003);
    chk("n_resf", result_flag, 32'h0000_0004);
    chk("n_busy", {31'd0, busy}, 32'd0);
    chk("n_words", {28'd0, words_loaded}, 32'd3);
    chk("n_low", low_cnt - l0, 32'd5);
    chk("n_done", done_cnt - d0, 32'd1);
    chk("n_writes", wr_cnt - w0, 32'd3);
    for (int i = 0; i < 3; i++) chk("n_waddr", {29'd0, wr_addr_q[qb+i]}, i);

    // Backpressure gaps: valid 1,0,0,1,1 with last on 3rd accepted.
    w0 = wr_cnt; qb = wr_addr_q.size();
    do_start(16'd2);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i];
      in_data  = 32'h100 + i;
      in_last  = pat[i] && (acc == 2);
      #1;
      chk("bp_we", {31'd0, imem_we}, {31'd0, pat[i]});
      if (pat[i]) begin
        chk("bp_addr", {29'd0, imem_addr}, acc);
        acc++;
      end
      cyc();
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_writes", wr_cnt - w0, 32'd3);
    for (int i = 0; i < 3; i++) chk("bp_waddr", {29'd0, wr_addr_q[qb+i]}, i);
    wait_done(50, n);
    chk("bp_run_len", n, 32'd2);
    cyc();

    // Overflow: 4 words without last at DEPTH=4.
    w0 = wr_cnt; l0 = low_cnt; d0 = done_cnt;
    do_start(16'd3);
    put_word("ov_w0", 32'hD0, 1'b0, 3'd0);
    put_word("ov_w1", 32'hD1, 1'b0, 3'd1);
    put_word("ov_w2", 32'hD2, 1'b0, 3'd2);
    put_word("ov_w3", 32'hD3, 1'b0, 3'd3);
    in_valid = 1'b1;
    #1;
    chk("ov_done", {31'd0, done}, 32'd1);
    chk("ov_error", {31'd0, error}, 32'd1);
    chk("ov_no_write", {31'd0, imem_we}, 32'd0);
    cyc();
    in_valid = 1'b0;
    chk("ov_writes", wr_cnt - w0, 32'd4);
    chk("ov_low", low_cnt - l0, 32'd0);
    chk("ov_dcnt", done_cnt - d0, 32'd1);
    chk("ov_sticky", {31'd0, error}, 32'd1);
    chk("ov_words", {28'd0, words_loaded}, 32'd4);

    // Full depth with last on the final address: normal completion.
    do_start(16'd1);
    chk("fd_err_clr", {31'd0, error}, 32'd0);
    put_word("fd_w0", 32'hE0, 1'b0, 3'd0);
    put_word("fd_w1", 32'hE1, 1'b0, 3'd1);
    put_word("fd_w2", 32'hE2, 1'b0, 3'd2);
    put_word("fd_w3", 32'hE3, 1'b1, 3'd3);
    chk("fd_error", {31'd0, error}, 32'd0);
    chk("fd_run", {31'd0, cpu_reset}, 32'd0);
    wait_done(50, n);
    chk("fd_run_len", n, 32'd1);
    cyc();
    chk("fd_words", {28'd0, words_loaded}, 32'd4);

    // Zero run cycles: LOAD straight to CAPTURE.
    l0 = low_cnt; d0 = done_cnt;
    do_start(16'd0);
    put_word("z_w0", 32'hF0, 1'b1, 3'd0);
    chk("z_done", {31'd0, done}, 32'd1);
    cyc();
    chk("z_low", low_cnt - l0, 32'd0);
    chk("z_dcnt", done_cnt - d0, 32'd1);

    // Start during RUN is ignored.
    l0 = low_cnt;
    do_start(16'd4);
    put_word("s_w0", 32'h55, 1'b1, 3'd0);
    start = 1'b1; run_cycles = 16'd9;
    cyc();
    start = 1'b0;
    wait_done(50, n);
    chk("s_run_len", n + 1, 32'd4);
    cyc();
    chk("s_low", low_cnt - l0, 32'd4);
    chk("s_idle", {31'd0, busy}, 32'd0);

    // Reset mid-RUN on the 3rd RUN cycle, start asserted alongside.
    d0 = done_cnt;
    do_start(16'd10);
    put_word("r_w0", 32'h66, 1'b1, 3'd0);
    cyc(); cyc();
    reset = 1'b0; start = 1'b1;
    cyc();
    reset = 1'b1; start = 1'b0;
    #1;
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("r_res0", result_reg0, 32'd0);
    chk("r_resf", result_flag, 32'd0);
    chk("r_words", {28'd0, words_loaded}, 32'd0);
    cyc(); cyc(); cyc();
    chk("r_dcnt", done_cnt - d0, 32'd0);
    chk("r_still_idle", {31'd0, busy}, 32'd0);

    // Reset beats a handshake in LOAD.
    w0 = wr_cnt;
    do_start(16'd2);
    reset = 1'b0; in_valid = 1'b1; in_last = 1'b1;
    #1;
    chk("rl_we", {31'd0, imem_we}, 32'd0);
    cyc();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("rl_busy", {31'd0, busy}, 32'd0);
    chk("rl_writes", wr_cnt - w0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
